// File: rtl/neuron_mac_accumulator.sv
// -----------------------------------------------------------------------------
// neuron_mac_accumulator
//
// Computes one neuron pre-activation in sign-magnitude arithmetic:
//    result = bias + sum(weight[i] * activation[i]), i = 0 .. N_INPUTS-1
// with an optional ReLU. The result feeds the activation/compare stage and
// follows the same format as the downstream 31-bit sign-magnitude adder.
//
// Format: MSB is the sign, the remaining bits are the magnitude. The code
// {1, all-zero} is reserved as the overflow marker (OVF); true zero is
// always emitted as +0.
//
// Ports
//    clk        system clock, rising edge
//    rst        synchronous active-high reset
//    start      pulse in IDLE begins a neuron and samples iBias
//    iBias      sign-magnitude bias (2*DATA_W-1 bits)
//    in_valid   beat valid
//    in_ready   beat accepted when in_valid & in_ready
//    iWeight    sign-magnitude weight (DATA_W bits)
//    iData      sign-magnitude activation (DATA_W bits)
//    out_valid  result valid
//    out_ready  consumer accepts the result
//    oSum       sign-magnitude result (2*DATA_W-1 bits)
//    overflow   sticky overflow flag for the current neuron
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; accumulator cleared and bias latched on start
// ACCUM  | in_ready=1, one product accumulated per accepted beat
// BIAS   | single cycle: add latched bias, apply ReLU, register the result
// DONE   | out_valid=1, result held until out_ready
// -----------------------------------------------------------------------------
module neuron_mac_accumulator #(
    parameter int DATA_W   = 16,
    parameter int N_INPUTS = 784,
    parameter bit RELU     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-2:0]   iBias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     iWeight,
    input  logic [DATA_W-1:0]     iData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-2:0]   oSum,
    output logic                  overflow
);

    localparam int ACC_W    = 2*DATA_W-1;
    localparam int MAG_W    = ACC_W-1;
    localparam int OP_MAG_W = DATA_W-1;
    localparam int CNT_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [ACC_W-1:0]  ACC_OVF   = {1'b1, {MAG_W{1'b0}}};
    localparam logic [DATA_W-1:0] OP_OVF    = {1'b1, {OP_MAG_W{1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N_INPUTS-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   bias_q;

    logic [ACC_W-1:0]   product;
    logic [ACC_W-1:0]   acc_plus_product;
    logic [ACC_W-1:0]   acc_plus_bias;
    logic [ACC_W-1:0]   bias_result;
    logic               beat_taken;

    // Sign-magnitude multiply. Two OP_MAG_W magnitudes always fit in MAG_W
    // bits, so the only overflow source is a poisoned (OVF) operand.
    function automatic logic [ACC_W-1:0] sm_mul(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [MAG_W-1:0] mag;
        logic [ACC_W-1:0] r;
        mag = MAG_W'(a[OP_MAG_W-1:0]) * MAG_W'(b[OP_MAG_W-1:0]);
        if (a == OP_OVF || b == OP_OVF)
            r = ACC_OVF;
        else if (mag == '0)
            r = '0;
        else
            r = {a[DATA_W-1] ^ b[DATA_W-1], mag};
        return r;
    endfunction

    // Sign-magnitude add matching the downstream adder, except that every
    // zero result is forced to +0 so -0 can never alias the OVF marker.
    function automatic logic [ACC_W-1:0] sm_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [MAG_W:0]   sum;
        logic [MAG_W-1:0] am;
        logic [MAG_W-1:0] bm;
        logic [ACC_W-1:0] r;
        am  = a[MAG_W-1:0];
        bm  = b[MAG_W-1:0];
        sum = {1'b0, am} + {1'b0, bm};
        if (a == ACC_OVF || b == ACC_OVF)
            r = ACC_OVF;
        else if (a[ACC_W-1] == b[ACC_W-1]) begin
            if (sum[MAG_W])
                r = ACC_OVF;
            else if (sum[MAG_W-1:0] == '0)
                r = '0;
            else
                r = {a[ACC_W-1], sum[MAG_W-1:0]};
        end
        else if (am > bm)
            r = {a[ACC_W-1], am - bm};
        else if (bm > am)
            r = {b[ACC_W-1], bm - am};
        else
            r = '0;
        return r;
    endfunction

    always_comb begin
        product          = sm_mul(iWeight, iData);
        acc_plus_product = sm_add(acc, product);
        acc_plus_bias    = sm_add(acc, bias_q);
        bias_result      = acc_plus_bias;
        // ReLU clamps genuine negatives only; OVF carries the sign bit too
        // but must reach the consumer unchanged.
        if (RELU && acc_plus_bias[ACC_W-1] && (acc_plus_bias != ACC_OVF))
            bias_result = '0;
        beat_taken = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            oSum      <= '0;
            overflow  <= 1'b0;
            count     <= '0;
            acc       <= '0;
            bias_q    <= '0;
        end
        else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                        acc      <= '0;
                        count    <= '0;
                        bias_q   <= iBias;
                        overflow <= 1'b0;
                    end
                end

                ACCUM: begin
                    if (beat_taken) begin
                        acc      <= acc_plus_product;
                        overflow <= overflow | (acc_plus_product == ACC_OVF);
                        // Counter parks on the last index instead of wrapping.
                        if (count == LAST_BEAT) begin
                            state    <= BIAS;
                            in_ready <= 1'b0;
                        end
                        else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                BIAS: begin
                    acc       <= bias_result;
                    oSum      <= bias_result;
                    overflow  <= overflow | (bias_result == ACC_OVF);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
